// File: rtl/fp_pkg.sv
// Shared types and format helpers for the floating-point add/sub block.
// Helpers take field values zero-extended to 64 bits so any EXP_LEN/MANTISSA_LEN below 64 works.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } fp_state_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic int fp_bias(input int exp_len);
    return (1 << (exp_len - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_exp_ones(input int exp_len);
    return (64'd1 << exp_len) - 64'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_len, input int mant_len);
    return (fp_exp_ones(exp_len) << mant_len) | (64'd1 << (mant_len - 1));
  endfunction

  function automatic logic fp_is_zero(input logic [63:0] exp_f);
    return exp_f == 64'd0;
  endfunction

  function automatic logic fp_is_inf(input logic [63:0] exp_f, input logic [63:0] frac_f,
                                     input int exp_len);
    return (exp_f == fp_exp_ones(exp_len)) && (frac_f == 64'd0);
  endfunction

  function automatic logic fp_is_nan(input logic [63:0] exp_f, input logic [63:0] frac_f,
                                     input int exp_len);
    return (exp_f == fp_exp_ones(exp_len)) && (frac_f != 64'd0);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH and raises zero_o.
module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic found;

  always_comb begin
    count_o = CNT_W'(WIDTH);
    found   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        count_o = CNT_W'(WIDTH - 1 - i);
        found   = 1'b1;
      end
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/fp_addsub_pipe_ctrl.sv
// Multi-cycle floating-point adder/subtractor with GRS rounding and special-value handling.
// Build macro FP_ROUND_RNE_EN selects round-to-nearest-even; without it results are truncated.
module fp_addsub_pipe_ctrl
  import fp_pkg::*;
#(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   a,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   b,
  input  logic                            op_sub,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [EXP_LEN+MANTISSA_LEN:0]   result,
  output logic [3:0]                      flags,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2:0]                      dbg_state_o
);

  localparam int M   = MANTISSA_LEN;
  localparam int W   = EXP_LEN + MANTISSA_LEN + 1;
  localparam int SW  = M + 4;                 // {hidden, frac, G, R, S}
  localparam int AW  = M + 5;                 // SW plus carry
  localparam int LZW = $clog2(SW + 1);
  localparam int EW  = EXP_LEN + LZW + 2;     // headroom for exp+1 and exp-lzc underflow
  localparam int SHW = LZW;

  localparam logic [EXP_LEN-1:0] EXP_ONES = EXP_LEN'(fp_exp_ones(EXP_LEN));
  localparam logic [EXP_LEN-1:0] EXP_MAXF = EXP_LEN'(fp_exp_ones(EXP_LEN) - 64'd1);
  localparam logic [W-1:0]       QNAN     = W'(fp_qnan(EXP_LEN, MANTISSA_LEN));

  // Handshakes: a transfer happens on a rising edge where valid && ready. in_ready is high
  // only in IDLE; out_valid is high only in DONE, where result/flags stay frozen until taken.
  fp_state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q;
  logic          sub_q;
  logic [SW-1:0] x_sig_q, y_sig_q;
  logic [EW-1:0] exp_q;
  logic          sign_q, eff_sub_q;
  logic          spec_q;
  logic [W-1:0]  spec_res_q;
  fp_flags_t     spec_flags_q;
  logic [AW-1:0] sum_q;
  logic [SW-1:0] norm_q;
  logic          zero_q;
  logic [W-1:0]  result_q;
  fp_flags_t     flags_q;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign flags       = flags_q;
  assign dbg_state_o = state_q;

  // ---------------- operand decode ----------------
  logic                sa, sb_eff;
  logic [EXP_LEN-1:0]  ea, eb;
  logic [M-1:0]        fa, fb;
  logic                za, zb, inf_a, inf_b, nan_a, nan_b;

  assign sa     = a_q[W-1];
  assign sb_eff = b_q[W-1] ^ sub_q;
  assign ea     = a_q[W-2 -: EXP_LEN];
  assign eb     = b_q[W-2 -: EXP_LEN];
  assign fa     = a_q[M-1:0];
  assign fb     = b_q[M-1:0];
  assign za     = fp_is_zero(64'(ea));
  assign zb     = fp_is_zero(64'(eb));
  assign inf_a  = fp_is_inf(64'(ea), 64'(fa), EXP_LEN);
  assign inf_b  = fp_is_inf(64'(eb), 64'(fb), EXP_LEN);
  assign nan_a  = fp_is_nan(64'(ea), 64'(fa), EXP_LEN);
  assign nan_b  = fp_is_nan(64'(eb), 64'(fb), EXP_LEN);

  // ---------------- ALIGN ----------------
  logic                a_ge_b, sx;
  logic [EXP_LEN-1:0]  ex, ey, diff;
  logic [M-1:0]        fx, fy;
  logic [SHW-1:0]      shamt;
  logic [SW-1:0]       y_full, y_shift, x_sig_d, y_sig_d;
  logic                y_lost;

  always_comb begin
    a_ge_b = ({ea, fa} >= {eb, fb});
    ex = ea; fx = fa; ey = eb; fy = fb; sx = sa;
    if (!a_ge_b) begin
      ex = eb; fx = fb; ey = ea; fy = fa; sx = sb_eff;
    end
    diff = ex - ey;
    if (32'(diff) > 32'(M + 3)) shamt = SHW'(M + 3);
    else                        shamt = SHW'(diff);
    y_full  = {1'b1, fy, 3'b000};
    y_shift = y_full >> shamt;
    y_lost  = |(y_full & ~({SW{1'b1}} << shamt));
    y_sig_d = {y_shift[SW-1:1], y_shift[0] | y_lost};
    x_sig_d = {1'b1, fx, 3'b000};
  end

  // Special operands resolved up front; ROUND lets them override the arithmetic path.
  logic          spec_d;
  logic [W-1:0]  spec_res_d;
  fp_flags_t     spec_flags_d;

  always_comb begin
    spec_d       = 1'b1;
    spec_res_d   = '0;
    spec_flags_d = '0;
    if (nan_a || nan_b) begin
      spec_res_d = QNAN;
    end else if (inf_a && inf_b) begin
      if (sa != sb_eff) begin
        spec_res_d           = QNAN;
        spec_flags_d.invalid = 1'b1;
      end else begin
        spec_res_d = a_q;
      end
    end else if (inf_a) begin
      spec_res_d = a_q;
    end else if (inf_b) begin
      spec_res_d = {sb_eff, b_q[W-2:0]};
    end else if (za && zb) begin
      spec_res_d = {sa & sb_eff, {(W-1){1'b0}}};
    end else if (za) begin
      spec_res_d = {sb_eff, b_q[W-2:0]};
    end else if (zb) begin
      spec_res_d = a_q;
    end else begin
      spec_d = 1'b0;
    end
  end

  // ---------------- ADD ----------------
  logic [AW-1:0] sum_d;

  always_comb begin
    if (eff_sub_q) sum_d = {1'b0, x_sig_q} - {1'b0, y_sig_q};
    else           sum_d = {1'b0, x_sig_q} + {1'b0, y_sig_q};
  end

  // ---------------- NORM ----------------
  logic [LZW-1:0] lz;
  logic           lz_zero;
  logic [SW-1:0]  norm_d;
  logic [EW-1:0]  exp_norm_d;
  logic           zero_d;

  fp_lzc #(
    .WIDTH (SW),
    .CNT_W (LZW)
  ) u_lzc (
    .data_i  (sum_q[SW-1:0]),
    .count_o (lz),
    .zero_o  (lz_zero)
  );

  always_comb begin
    zero_d = 1'b0;
    if (sum_q[AW-1]) begin
      norm_d     = {sum_q[AW-1:2], sum_q[1] | sum_q[0]};
      exp_norm_d = exp_q + EW'(1);
    end else begin
      norm_d     = sum_q[SW-1:0] << lz;
      exp_norm_d = exp_q - {{(EW-LZW){1'b0}}, lz};
      zero_d     = lz_zero;
    end
  end

  // ---------------- ROUND ----------------
  logic [M:0]    mant;
  logic [M-1:0]  frac_r;
  logic [EW-1:0] exp_r;
  logic          inexact, ovf, unf;
  logic [W-1:0]  result_d;
  fp_flags_t     flags_d;
`ifdef FP_ROUND_RNE_EN
  logic          inc;
  logic [M+1:0]  rm;
`endif

  always_comb begin
    mant    = norm_q[SW-1:3];
    inexact = |norm_q[2:0];
`ifdef FP_ROUND_RNE_EN
    inc = norm_q[2] & (norm_q[1] | norm_q[0] | mant[0]);
    rm  = {1'b0, mant} + (M+2)'(inc);
    // A carry out of the mantissa leaves 1.000..0, so only the exponent moves.
    if (rm[M+1]) begin
      frac_r = rm[M:1];
      exp_r  = exp_q + EW'(1);
    end else begin
      frac_r = rm[M-1:0];
      exp_r  = exp_q;
    end
`else
    frac_r = mant[M-1:0];
    exp_r  = exp_q;
`endif
    ovf = !exp_r[EW-1] && (exp_r >= {{(EW-EXP_LEN){1'b0}}, EXP_ONES});
    unf = exp_r[EW-1] || (exp_r == '0);

    result_d = {sign_q, exp_r[EXP_LEN-1:0], frac_r};
    flags_d  = '0;
    flags_d.inexact = inexact;
    if (spec_q) begin
      result_d = spec_res_q;
      flags_d  = spec_flags_q;
    end else if (zero_q) begin
      result_d = '0;
      flags_d  = '0;
    end else if (ovf) begin
`ifdef FP_ROUND_RNE_EN
      result_d = {sign_q, EXP_ONES, {M{1'b0}}};
`else
      result_d = {sign_q, EXP_MAXF, {M{1'b1}}};
`endif
      flags_d.overflow = 1'b1;
      flags_d.inexact  = 1'b1;
    end else if (unf) begin
      result_d          = {sign_q, {(W-1){1'b0}}};
      flags_d.underflow = 1'b1;
      flags_d.inexact   = 1'b1;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      x_sig_q      <= '0;
      y_sig_q      <= '0;
      exp_q        <= '0;
      sign_q       <= 1'b0;
      eff_sub_q    <= 1'b0;
      spec_q       <= 1'b0;
      spec_res_q   <= '0;
      spec_flags_q <= '0;
      sum_q        <= '0;
      norm_q       <= '0;
      zero_q       <= 1'b0;
      result_q     <= '0;
      flags_q      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= op_sub;
          end
        end
        ALIGN: begin
          x_sig_q      <= x_sig_d;
          y_sig_q      <= y_sig_d;
          exp_q        <= {{(EW-EXP_LEN){1'b0}}, ex};
          sign_q       <= sx;
          eff_sub_q    <= sa ^ sb_eff;
          spec_q       <= spec_d;
          spec_res_q   <= spec_res_d;
          spec_flags_q <= spec_flags_d;
        end
        ADD: begin
          sum_q <= sum_d;
        end
        NORM: begin
          norm_q <= norm_d;
          exp_q  <= exp_norm_d;
          zero_q <= zero_d;
        end
        ROUND: begin
          result_q <= result_d;
          flags_q  <= flags_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe_ctrl.sv
// Directed self-checking bench for fp_addsub_pipe_ctrl (single precision, either rounding build).
module tb_fp_addsub_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        op_sub = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  fl;
    string       name;
  } vec_t;

  fp_addsub_pipe_ctrl #(.EXP_LEN(8), .MANTISSA_LEN(23)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .op_sub      (op_sub),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .result      (result),
    .flags       (flags),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // Latency is counted in rising edges, the accept edge being edge 1.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    int n;
    @(negedge clk);
    a = ta; b = tb; op_sub = ts; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r = result;
    f = flags;
  endtask

  task automatic pop_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 00000000", result); end
    checks++;
    if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %h exp 0", flags); end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic run_table(input vec_t v[$]);
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, v[i].sub, r, f, lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL %s_latency got %0d exp 5", v[i].name, lat); end
      checks++;
      if (r !== v[i].res) begin errors++; $display("FAIL %s_result got %h exp %h", v[i].name, r, v[i].res); end
      checks++;
      if (f !== v[i].fl) begin errors++; $display("FAIL %s_flags got %b exp %b", v[i].name, f, v[i].fl); end
      pop_result();
    end
  endtask

  task automatic test_add_sub();
    vec_t v[$];
    v.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, "add_1p1"});
    v.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, "sub_1m1"});
    v.push_back('{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, "negzero"});
    v.push_back('{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000, "sub_2m1"});
    v.push_back('{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, "sub_1m2"});
    v.push_back('{32'h00000000, 32'h3FC00000, 1'b1, 32'hBFC00000, 4'b0000, "zero_m_x"});
    v.push_back('{32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000, "add_3p1"});
    run_table(v);
  endtask

  task automatic test_rounding();
    vec_t v[$];
`ifdef FP_ROUND_RNE_EN
    v.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie_even"});
    v.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, "tie_odd"});
    v.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, "overflow"});
`else
    v.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie_even"});
    v.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 4'b0001, "tie_odd"});
    v.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 4'b0101, "overflow"});
`endif
    v.push_back('{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, "underflow"});
    run_table(v);
  endtask

  task automatic test_specials();
    vec_t v[$];
    v.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, "inf_m_inf"});
    v.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, "inf_sub_inf"});
    v.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, "nan_in"});
    v.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, "inf_p_x"});
    v.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, "x_m_inf"});
    run_table(v);
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    int          bad_cycles;
    int          seen;
    run_op(32'h3FC00000, 32'h3FC00000, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'h40400000) begin errors++; $display("FAIL hold_result got %h exp 40400000", r); end
    bad_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      a = 32'($urandom_range(0, 32'h3FFFFFFF));
      b = 32'h3F800000;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h40400000 || flags !== 4'h0)
        bad_cycles++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad_cycles !== 0) begin
      errors++;
      $display("FAIL hold_stable got %0d unstable cycles exp 0", bad_cycles);
    end
    pop_result();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL busy_ignored got %0d valid cycles exp 0", seen); end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    int bad;
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    bad = 0;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        hits.push_back(k);
        if (result !== 32'h40000000) bad++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (hits.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", hits.size()); end
    else begin
      checks++;
      if (hits[0] !== 5) begin errors++; $display("FAIL b2b_first got %0d exp 5", hits[0]); end
      checks++;
      if (hits[1] - hits[0] !== 6 || hits[2] - hits[1] !== 6) begin
        errors++;
        $display("FAIL b2b_period got %0d,%0d exp 6,6", hits[1] - hits[0], hits[2] - hits[1]);
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_result got %0d bad results exp 0", bad); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b exp 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    int          seen;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (dbg_state !== 3'd3) begin errors++; $display("FAIL mid_state got %0d exp 3", dbg_state); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", in_ready); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL mid_rst_result got %h exp 00000000", result); end
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_rst_stale got %0d valid cycles exp 0", seen); end
    run_op(32'h3F800000, 32'h40000000, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'h40400000 || lat !== 5) begin
      errors++;
      $display("FAIL mid_rst_recover got %h lat %0d exp 40400000 lat 5", r, lat);
    end
    pop_result();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_reset();
    test_add_sub();
    test_rounding();
    test_specials();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe_ctrl.md
Name: fp_addsub_pipe_ctrl

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor. It is the successor to the team's single-format adder FSM and adds the following:
- valid/ready handshakes on both sides
- a selectable add/sub operation
- guard/round/sticky rounding
- special-value handling (zero, inf, NaN) and exception flags

It sits between operand-fetch logic and result writeback in the arithmetic datapath.

Parameters:
EXP_LEN, 8, exponent field width (bias = 2^(EXP_LEN-1)-1)
MANTISSA_LEN, 23, stored fraction width (hidden bit implicit)

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
a  input  EXP_LEN+MANTISSA_LEN+1  operand A {sign, exp, frac}
b  input  EXP_LEN+MANTISSA_LEN+1  operand B
op_sub  input  1  1 = compute a-b, 0 = a+b
in_valid  input  1  operands/op_sub valid
in_ready  output  1  block can accept operands
result  output  EXP_LEN+MANTISSA_LEN+1  packed result
flags  output  4  {invalid, overflow, underflow, inexact}
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, result=0, flags=0, all datapath registers 0. Reset mid-operation aborts the operation; nothing is emitted.
- in_ready = (state==IDLE). Accept on in_valid&&in_ready; capture a, b and op_sub.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
  - DONE holds result/flags stable with out_valid=1 until out_ready.
  - DONE -> IDLE on out_valid&&out_ready.
  - No overlap between operations. Fixed latency is 5 cycles from accept edge to out_valid=1; the special-case path takes the same latency.
- Operand rules:
  - exp==0 is treated as zero; no subnormals, and frac is ignored.
  - exp==all-ones with frac==0 is inf; with frac!=0 it is NaN.
- Effective sign of B: sb_eff = sign_b ^ op_sub. Effective subtract = sign_a ^ sb_eff.
- ALIGN:
  - Swap so X has the larger {exp, mant}.
  - Right-shift the smaller significand by the exponent difference into a MANTISSA_LEN+4-bit field {hidden, frac, G, R, S}. Shifted-out bits are OR-ed into S.
  - Shift amount saturates at MANTISSA_LEN+3.
- ADD:
  - Add or subtract (X-Y, never negative) in MANTISSA_LEN+5 bits, with carry.
  - Result sign = sign of X.
- NORM:
  - Carry set: shift right 1, fold the dropped bit into S, exp+1.
  - Otherwise: shift left by the leading-zero count, exp-lzc.
  - Zero significand: exact zero, sign +0, except (-0)+(-0) = -0.
- ROUND:
  - Inexact = G|R|S.
  - Rounding mode per the optional feature below.
  - A mantissa carry-out after rounding increments exp and renormalises.
- Range:
  - exp >= all-ones -> ±inf, overflow=1, inexact=1.
  - exp <= 0 -> flush to ±0, underflow=1, inexact=1.
- Specials (override the arithmetic result in ROUND):
  - Any NaN input -> canonical qNaN {0, all-ones, 1 followed by zeros}.
  - inf + (-inf) effective -> qNaN, invalid=1.
  - inf with a finite operand -> that inf, flags 0.
  - zero with x -> x exactly.
- Boundaries:
  - in_valid while busy is ignored; in_ready stays 0.
  - out_ready high before DONE has no effect.
  - out_ready held high gives one result per 6 cycles.

Optional Feature:
FP_ROUND_RNE_EN
- Defined: round to nearest, ties to even. Increment when G&(R|S|lsb).
- Undefined: truncate (round toward zero). No increment logic, so overflow saturates to the max finite value instead of inf.
- The inexact flag behaves identically in both builds.

Decomposition:
- Package fp_pkg holds:
  - enum fp_state_t {IDLE, ALIGN, ADD, NORM, ROUND, DONE}
  - struct fp_flags_t {invalid, overflow, underflow, inexact}
  - localparam functions for bias, all-ones exponent and canonical qNaN, parametrised by EXP_LEN/MANTISSA_LEN
  - classify helpers is_zero/is_inf/is_nan
- Sub-module fp_lzc: parametrised combinational leading-zero counter used in NORM.

Test Plan:
- a=0x3F800000, b=0x3F800000, op_sub=0 -> result 0x40000000, flags 0; out_valid exactly 5 cycles after accept.
- a=0x3F800000, b=0x3F800000, op_sub=1 -> 0x00000000, flags 0. Then a=0x80000000, b=0x00000000, op_sub=1 -> 0x80000000.
- RNE build:
  - 0x3F800000+0x33800000 (tie) -> 0x3F800000, inexact=1.
  - 0x3F800001+0x33800000 -> 0x3F800002.
  - Truncate build, first case -> 0x3F800000.
- 0x7F7FFFFF+0x7F7FFFFF -> RNE: 0x7F800000, overflow=1, inexact=1. Truncate build: 0x7F7FFFFF, overflow=1.
- 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1. Also 0x7FC00001 + 1.0 -> 0x7FC00000, invalid=0.
- Hold out_ready=0 for 10 cycles -> result stable, in_ready=0 throughout. Assert rst_n=0 during NORM of a second op -> out_valid=0 immediately, in_ready=1 after release, no stale result emitted.
